lzx_74hc138_seq: RTL and testbench

- Sequential 3-to-8 decoder. It is the receive end of the lzx_74HC148 priority-encoder interface.
- Accepts the active-low code (code_n) and group-select (gs_n) produced by the 8-to-3 encoder.
- Qualifies the code for stability, then latches an active-low one-hot output with a valid flag until the consumer acknowledges.
- Uses 74HC138-style enables (g1, g2a_n, g2b_n). Round trip: encoder din=8'b11111110 -> code_n=3'b111 -> dout_n=8'b11111110.

---
 rtl/lzx_74hc138_seq.sv | 165 ++++++++++++++++
 tb/tb_lzx_74hc138_seq.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/lzx_74hc138_seq.sv
// Sequential 3-to-8 decoder: qualifies the encoder code, then latches an active-low one-hot line until ack or timeout.
// Optional capture counter built only when LZX_138_EVTCNT_EN is defined; otherwise evt_cnt is tied to zero.
module lzx_74hc138_seq #(
    parameter int STABLE_CYC = 2,
    parameter int TIMEOUT    = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] code_n,
    input  logic       gs_n,
    input  logic       g1,
    input  logic       g2a_n,
    input  logic       g2b_n,
    input  logic       ack,
    output logic [7:0] dout_n,
    output logic       valid,
    output logic       busy,
    output logic       tout,
    output logic [7:0] evt_cnt
);

    // state  | meaning
    // IDLE   | waiting for an enabled request
    // QUAL   | counting consecutive identical codes
    // HOLD   | line latched, waiting for ack or timeout
    // REARM  | released, waiting for the request to drop
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_QUAL  = 2'd1,
        S_HOLD  = 2'd2,
        S_REARM = 2'd3
    } state_t;

    localparam logic [3:0]  STABLE_W  = 4'(STABLE_CYC);
    localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

    state_t      state_q;
    logic [2:0]  cand_q;
    logic [3:0]  cnt_q;
    logic [15:0] tmo_q;
    logic [7:0]  dout_n_q;
    logic        valid_q;
    logic        busy_q;
    logic        tout_q;

    logic        en;
    logic        req;
    logic [3:0]  cnt_d;
    logic [15:0] tmo_d;
    logic        tmo_hit;
    logic        hold_enter;

    function automatic logic [7:0] decode_n(input logic [2:0] c);
        logic [7:0] d;
        d      = 8'hFF;
        d[~c]  = 1'b0;
        return d;
    endfunction

    always_comb begin
        en         = g1 & ~g2a_n & ~g2b_n;
        req        = en & ~gs_n;
        cnt_d      = cnt_q + 4'd1;
        tmo_d      = tmo_q + 16'd1;
        tmo_hit    = (TIMEOUT_W != 16'd0) && (tmo_d == TIMEOUT_W);
        hold_enter = 1'b0;
        // In QUAL the capture code equals cand, so code_n is used for both entry paths.
        if (state_q == S_IDLE)
            hold_enter = req && (STABLE_W == 4'd1);
        else if (state_q == S_QUAL)
            hold_enter = req && (code_n == cand_q) && (cnt_d == STABLE_W);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cand_q   <= 3'd0;
            cnt_q    <= 4'd0;
            tmo_q    <= 16'd0;
            dout_n_q <= 8'hFF;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            tout_q   <= 1'b0;
        end else begin
            tout_q <= 1'b0;
            if (hold_enter) begin
                state_q  <= S_HOLD;
                cand_q   <= code_n;
                cnt_q    <= cnt_d;
                tmo_q    <= 16'd0;
                dout_n_q <= decode_n(code_n);
                valid_q  <= 1'b1;
                busy_q   <= 1'b1;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (req) begin
                            state_q <= S_QUAL;
                            cand_q  <= code_n;
                            cnt_q   <= 4'd1;
                            busy_q  <= 1'b1;
                        end
                    end
                    S_QUAL: begin
                        if (!req) begin
                            state_q <= S_IDLE;
                            cnt_q   <= 4'd0;
                            busy_q  <= 1'b0;
                        end else if (code_n != cand_q) begin
                            cand_q <= code_n;
                            cnt_q  <= 4'd1;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                    S_HOLD: begin
                        // ack has priority, so a coincident timeout never pulses tout.
                        if (ack || tmo_hit) begin
                            state_q  <= S_REARM;
                            dout_n_q <= 8'hFF;
                            valid_q  <= 1'b0;
                            tout_q   <= ~ack;
                            cnt_q    <= 4'd0;
                        end else begin
                            tmo_q <= tmo_d;
                        end
                    end
                    S_REARM: begin
                        if (!req) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                    default: begin
                        state_q  <= S_IDLE;
                        dout_n_q <= 8'hFF;
                        valid_q  <= 1'b0;
                        busy_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef LZX_138_EVTCNT_EN
    logic [7:0] evt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            evt_q <= 8'h00;
        else if (hold_enter)
            evt_q <= evt_q + 8'h01;
    end

    assign evt_cnt = evt_q;
`else
    assign evt_cnt = 8'h00;
`endif

    assign dout_n = dout_n_q;
    assign valid  = valid_q;
    assign busy   = busy_q;
    assign tout   = tout_q;

endmodule

// File: tb/tb_lzx_74hc138_seq.sv
// Directed bench for lzx_74hc138_seq with STABLE_CYC=2, TIMEOUT=4.
module tb_lzx_74hc138_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] code_n;
    logic       gs_n, g1, g2a_n, g2b_n, ack;
    logic [7:0] dout_n, evt_cnt;
    logic       valid, busy, tout;

    int n_chk = 0;
    int n_err = 0;
    int ev    = 0;

    lzx_74hc138_seq #(.STABLE_CYC(2), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .code_n(code_n), .gs_n(gs_n),
        .g1(g1), .g2a_n(g2a_n), .g2b_n(g2b_n), .ack(ack),
        .dout_n(dout_n), .valid(valid), .busy(busy), .tout(tout),
        .evt_cnt(evt_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] line_n(input logic [2:0] c);
        case (c)
            3'b111:  return 8'hFE;
            3'b110:  return 8'hFD;
            3'b101:  return 8'hFB;
            3'b100:  return 8'hF7;
            3'b011:  return 8'hEF;
            3'b010:  return 8'hDF;
            3'b001:  return 8'hBF;
            default: return 8'h7F;
        endcase
    endfunction

    function automatic logic [7:0] evt_exp();
`ifdef LZX_138_EVTCNT_EN
        return ev[7:0];
`else
        return 8'h00;
`endif
    endfunction

    task automatic capture(input logic [2:0] c);
        gs_n = 1'b0; code_n = c;
        step(); step();
        chk("cap_dout", dout_n, line_n(c));
        chk("cap_valid", valid, 1'b1);
        ev++;
        ack = 1'b1;
        step();
        ack = 1'b0; gs_n = 1'b1;
        step();
    endtask

    initial begin
        rst = 1'b1; code_n = 3'b111; gs_n = 1'b1;
        g1 = 1'b1; g2a_n = 1'b0; g2b_n = 1'b0; ack = 1'b0;

        // Reset values
        step(); step();
        chk("rst_dout", dout_n, 8'hFF);
        chk("rst_valid", valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_tout", tout, 1'b0);
        chk("rst_evt", evt_cnt, 8'h00);
        rst = 1'b0;
        step();

        // Round trip 111 -> FE
        gs_n = 1'b0; code_n = 3'b111;
        step();
        chk("rt_qual_valid", valid, 1'b0);
        chk("rt_qual_busy", busy, 1'b1);
        chk("rt_qual_dout", dout_n, 8'hFF);
        step();
        chk("rt_dout", dout_n, 8'hFE);
        chk("rt_valid", valid, 1'b1);
        ev++;
        ack = 1'b1;
        step();
        chk("rt_rel_dout", dout_n, 8'hFF);
        chk("rt_rel_valid", valid, 1'b0);
        chk("rt_rel_busy", busy, 1'b1);
        chk("rt_rel_tout", tout, 1'b0);
        ack = 1'b0;
        step();
        chk("rt_rearm_busy", busy, 1'b1);
        gs_n = 1'b1;
        step();
        chk("rt_idle_busy", busy, 1'b0);

        // Glitch rejection
        gs_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            code_n = (i % 2 == 0) ? 3'b000 : 3'b001;
            step();
            chk("gl_valid", valid, 1'b0);
        end
        code_n = 3'b000;
        step();
        chk("gl_settle_valid", valid, 1'b0);
        step();
        chk("gl_dout", dout_n, 8'h7F);
        chk("gl_valid_hi", valid, 1'b1);
        ev++;
        ack = 1'b1;
        step();
        ack = 1'b0; gs_n = 1'b1;
        step();
        chk("gl_idle_busy", busy, 1'b0);

        // Enable gating; ack in IDLE is ignored
        gs_n = 1'b0; code_n = 3'b010; g2a_n = 1'b1; ack = 1'b1;
        step(); step(); step();
        chk("en_g2a_busy", busy, 1'b0);
        chk("en_g2a_dout", dout_n, 8'hFF);
        g2a_n = 1'b0; g1 = 1'b0;
        step(); step();
        chk("en_g1_busy", busy, 1'b0);
        chk("en_g1_dout", dout_n, 8'hFF);
        g1 = 1'b1; ack = 1'b0;
        step(); step();
        chk("en_hold_dout", dout_n, 8'hDF);
        ev++;
        g1 = 1'b0; g2a_n = 1'b1; gs_n = 1'b1; code_n = 3'b101;
        step(); step();
        chk("en_frozen_dout", dout_n, 8'hDF);
        chk("en_frozen_valid", valid, 1'b1);
        ack = 1'b1;
        step();
        chk("en_rel_valid", valid, 1'b0);
        ack = 1'b0; g1 = 1'b1; g2a_n = 1'b0;
        step();
        chk("en_idle_busy", busy, 1'b0);

        // Timeout release with one tout pulse
        gs_n = 1'b0; code_n = 3'b011;
        step(); step();
        chk("to_dout", dout_n, 8'hEF);
        chk("to_entry_tout", tout, 1'b0);
        ev++;
        for (int i = 1; i <= 3; i++) begin
            step();
            chk("to_hold_valid", valid, 1'b1);
            chk("to_hold_tout", tout, 1'b0);
        end
        step();
        chk("to_rel_valid", valid, 1'b0);
        chk("to_rel_dout", dout_n, 8'hFF);
        chk("to_pulse", tout, 1'b1);
        chk("to_rel_busy", busy, 1'b1);
        step();
        chk("to_pulse_end", tout, 1'b0);
        chk("to_rearm_busy", busy, 1'b1);
        step();
        chk("to_rearm_busy2", busy, 1'b1);
        chk("to_rearm_valid", valid, 1'b0);
        gs_n = 1'b1;
        step();
        chk("to_idle_busy", busy, 1'b0);

        // Ack coincident with the timeout edge
        gs_n = 1'b0; code_n = 3'b100;
        step(); step();
        chk("ta_dout", dout_n, 8'hF7);
        ev++;
        step(); step(); step();
        ack = 1'b1;
        step();
        chk("ta_rel_valid", valid, 1'b0);
        chk("ta_tout", tout, 1'b0);
        ack = 1'b0;
        step();
        chk("ta_tout_after", tout, 1'b0);
        gs_n = 1'b1;
        step();

        // Event counter
        chk("evt_5", evt_cnt, evt_exp());
        for (int i = 0; i < 251; i++)
            capture(3'(i % 8));
        chk("evt_wrap", evt_cnt, evt_exp());
        capture(3'b110);
        chk("evt_after_wrap", evt_cnt, evt_exp());

        // Asynchronous reset mid-HOLD
        gs_n = 1'b0; code_n = 3'b110;
        step(); step();
        chk("rh_hold_dout", dout_n, 8'hFD);
        @(negedge clk);
        rst = 1'b1;
        #1;
        ev = 0;
        chk("rh_dout", dout_n, 8'hFF);
        chk("rh_valid", valid, 1'b0);
        chk("rh_busy", busy, 1'b0);
        chk("rh_tout", tout, 1'b0);
        chk("rh_evt", evt_cnt, 8'h00);
        step();
        chk("rh_dout_held", dout_n, 8'hFF);
        rst = 1'b0; gs_n = 1'b1;
        step();
        chk("rh_idle_busy", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
